// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/stall controller: FSM encodings and
// register-address constants.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MUL_BUSY = 2'b01
    } hz_state_e;

endpackage

// File: rtl/hazard_stall_unit_reg_match.sv
// Nonzero equality comparator for register specifiers; $0 never matches
// because writes to it are discarded and cannot create a dependence.
module reg_match
    import hazard_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] a_i,
    input  logic [REG_ADDR_W-1:0] b_i,
    output logic                  match_o
);

    assign match_o = (a_i == b_i) && (a_i != ZERO_REG);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use and branch-in-ID
// dependences, multicycle multiply occupancy, and a saturating stall counter.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int PERF_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs,
    input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRt,
    input  logic                  ID_UsesRt,
    input  logic                  ID_Branch,
    input  logic                  ID_BranchTaken,
    input  logic                  ID_EX_MemRead,
    input  logic                  ID_EX_RegWrite,
    input  logic [REG_ADDR_W-1:0] ID_EX_RegisterRd,
    input  logic                  EX_MEM_MemRead,
    input  logic [REG_ADDR_W-1:0] EX_MEM_RegisterRd,
    input  logic                  EX_MulStart,
    output logic                  PCWrite,
    output logic                  IF_ID_Write,
    output logic                  ID_EX_Bubble,
    output logic                  ID_EX_Hold,
    output logic                  EX_MEM_Bubble,
    output logic                  IF_ID_Flush,
    output logic [1:0]            HazardState,
    output logic [PERF_WIDTH-1:0] StallCycles
);

    localparam logic [3:0] MUL_INIT = 4'(MUL_LATENCY - 2);

    hz_state_e             state_q, state_d;
    logic [3:0]            mul_cnt_q, mul_cnt_d;
    logic [PERF_WIDTH-1:0] stall_cnt_q;

    logic lu_rs_s, lu_rt_s, bx_rs_s, bx_rt_s, bm_rs_s, bm_rt_s;
    logic load_use_s, br_ex_s, br_mem_s, data_stall_s;
    logic pc_write_s, if_id_write_s, id_ex_bubble_s, id_ex_hold_s;
    logic ex_mem_bubble_s, if_id_flush_s;

    reg_match u_lu_rs (.a_i(ID_EX_RegisterRd),  .b_i(IF_ID_RegisterRs), .match_o(lu_rs_s));
    reg_match u_lu_rt (.a_i(ID_EX_RegisterRd),  .b_i(IF_ID_RegisterRt), .match_o(lu_rt_s));
    reg_match u_bx_rs (.a_i(ID_EX_RegisterRd),  .b_i(IF_ID_RegisterRs), .match_o(bx_rs_s));
    reg_match u_bx_rt (.a_i(ID_EX_RegisterRd),  .b_i(IF_ID_RegisterRt), .match_o(bx_rt_s));
    reg_match u_bm_rs (.a_i(EX_MEM_RegisterRd), .b_i(IF_ID_RegisterRs), .match_o(bm_rs_s));
    reg_match u_bm_rt (.a_i(EX_MEM_RegisterRd), .b_i(IF_ID_RegisterRt), .match_o(bm_rt_s));

    assign load_use_s   = ID_EX_MemRead && (lu_rs_s || (lu_rt_s && ID_UsesRt));
    assign br_ex_s      = ID_Branch && ID_EX_RegWrite && (bx_rs_s || bx_rt_s);
    assign br_mem_s     = ID_Branch && EX_MEM_MemRead && (bm_rs_s || bm_rt_s);
    assign data_stall_s = load_use_s || br_ex_s || br_mem_s;

    // Next-state, multiply countdown and per-state pipeline controls
    always_comb begin
        state_d         = state_q;
        mul_cnt_d       = mul_cnt_q;
        pc_write_s      = 1'b0;
        if_id_write_s   = 1'b0;
        id_ex_bubble_s  = 1'b1;
        id_ex_hold_s    = 1'b0;
        ex_mem_bubble_s = 1'b0;
        if_id_flush_s   = 1'b0;
        case (state_q)
            RUN: begin
                if (EX_MulStart) begin
                    state_d   = MUL_BUSY;
                    mul_cnt_d = MUL_INIT;
                end else begin
                    state_d   = RUN;
                end
                if (data_stall_s) begin
                    pc_write_s     = 1'b0;
                    if_id_write_s  = 1'b0;
                    id_ex_bubble_s = 1'b1;
                    if_id_flush_s  = 1'b0;
                end else begin
                    pc_write_s     = 1'b1;
                    if_id_write_s  = 1'b1;
                    id_ex_bubble_s = 1'b0;
                    if_id_flush_s  = ID_BranchTaken;
                end
            end
            MUL_BUSY: begin
                id_ex_bubble_s  = 1'b0;
                id_ex_hold_s    = 1'b1;
                ex_mem_bubble_s = 1'b1;
                if (mul_cnt_q == 4'd0) begin
                    state_d   = RUN;
                    mul_cnt_d = 4'd0;
                end else begin
                    mul_cnt_d = mul_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d   = RUN;
                mul_cnt_d = 4'd0;
            end
        endcase
    end

    // FSM state and multiply countdown registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= RUN;
            mul_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt_q <= '0;
        end else if (!pc_write_s && (stall_cnt_q != {PERF_WIDTH{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + {{(PERF_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    // Reset overrides the decode asynchronously so the pipeline freezes at once
    assign PCWrite       = Rst & pc_write_s;
    assign IF_ID_Write   = Rst & if_id_write_s;
    assign ID_EX_Bubble  = ~Rst | id_ex_bubble_s;
    assign ID_EX_Hold    = Rst & id_ex_hold_s;
    assign EX_MEM_Bubble = Rst & ex_mem_bubble_s;
    assign IF_ID_Flush   = Rst & if_id_flush_s;
    assign HazardState   = state_q;
    assign StallCycles   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit (MUL_LATENCY=4, PERF_WIDTH=4).
module tb_hazard_stall_unit;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [4:0] IF_ID_RegisterRs, IF_ID_RegisterRt, ID_EX_RegisterRd, EX_MEM_RegisterRd;
    logic       ID_UsesRt, ID_Branch, ID_BranchTaken, ID_EX_MemRead, ID_EX_RegWrite;
    logic       EX_MEM_MemRead, EX_MulStart;
    logic       PCWrite, IF_ID_Write, ID_EX_Bubble, ID_EX_Hold, EX_MEM_Bubble, IF_ID_Flush;
    logic [1:0] HazardState;
    logic [3:0] StallCycles;

    int errors = 0;
    int checks = 0;

    hazard_stall_unit #(.MUL_LATENCY(4), .PERF_WIDTH(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
        .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_RegisterRd(ID_EX_RegisterRd), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_RegisterRd(EX_MEM_RegisterRd), .EX_MulStart(EX_MulStart),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
        .ID_EX_Hold(ID_EX_Hold), .EX_MEM_Bubble(EX_MEM_Bubble), .IF_ID_Flush(IF_ID_Flush),
        .HazardState(HazardState), .StallCycles(StallCycles)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs;
        IF_ID_RegisterRs = 5'd0; IF_ID_RegisterRt = 5'd0; ID_EX_RegisterRd = 5'd0;
        EX_MEM_RegisterRd = 5'd0; ID_UsesRt = 1'b0; ID_Branch = 1'b0; ID_BranchTaken = 1'b0;
        ID_EX_MemRead = 1'b0; ID_EX_RegWrite = 1'b0; EX_MEM_MemRead = 1'b0; EX_MulStart = 1'b0;
    endtask

    // {PCWrite, IF_ID_Write, ID_EX_Bubble, ID_EX_Hold, EX_MEM_Bubble, IF_ID_Flush}
    function automatic logic [5:0] ctl();
        return {PCWrite, IF_ID_Write, ID_EX_Bubble, ID_EX_Hold, EX_MEM_Bubble, IF_ID_Flush};
    endfunction

    task automatic test_reset;
        Rst = 1'b0;
        idle_inputs();
        #1;
        checks++; if (ctl() !== 6'b001000) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), 6'b001000); end
        checks++; if (HazardState !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", HazardState); end
        checks++; if (StallCycles !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", StallCycles); end
        tick();
        Rst = 1'b1;
        #1;
        checks++; if (ctl() !== 6'b110000) begin errors++; $display("FAIL release_run got=%b exp=%b", ctl(), 6'b110000); end
        tick();
        checks++; if (StallCycles !== 4'd0) begin errors++; $display("FAIL release_cnt got=%0d exp=0", StallCycles); end
    endtask

    task automatic test_load_use;
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRd = 5'd8; IF_ID_RegisterRs = 5'd8;
        #1;
        checks++; if (ctl() !== 6'b001000) begin errors++; $display("FAIL load_use_rs got=%b exp=%b", ctl(), 6'b001000); end
        tick();
        checks++; if (StallCycles !== 4'd1) begin errors++; $display("FAIL load_use_cnt got=%0d exp=1", StallCycles); end
        ID_EX_RegisterRd = 5'd0; IF_ID_RegisterRs = 5'd0;
        #1;
        checks++; if (ctl() !== 6'b110000) begin errors++; $display("FAIL load_use_r0 got=%b exp=%b", ctl(), 6'b110000); end
        tick();
        checks++; if (StallCycles !== 4'd1) begin errors++; $display("FAIL load_use_r0_cnt got=%0d exp=1", StallCycles); end
        idle_inputs();
    endtask

    task automatic test_rt_gating;
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRd = 5'd9; IF_ID_RegisterRt = 5'd9;
        IF_ID_RegisterRs = 5'd3; ID_UsesRt = 1'b0;
        #1;
        checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL rt_unused got=%b exp=1", PCWrite); end
        ID_UsesRt = 1'b1;
        #1;
        checks++; if (ctl() !== 6'b001000) begin errors++; $display("FAIL rt_used got=%b exp=%b", ctl(), 6'b001000); end
        tick();
        checks++; if (StallCycles !== 4'd2) begin errors++; $display("FAIL rt_cnt got=%0d exp=2", StallCycles); end
        idle_inputs();
    endtask

    task automatic test_branch;
        ID_Branch = 1'b1; ID_BranchTaken = 1'b1; ID_EX_RegWrite = 1'b1;
        ID_EX_RegisterRd = 5'd5; IF_ID_RegisterRs = 5'd5;
        #1;
        checks++; if (ctl() !== 6'b001000) begin errors++; $display("FAIL br_ex got=%b exp=%b", ctl(), 6'b001000); end
        tick();
        ID_EX_RegWrite = 1'b0; ID_EX_RegisterRd = 5'd0;
        EX_MEM_MemRead = 1'b1; EX_MEM_RegisterRd = 5'd5;
        #1;
        checks++; if (ctl() !== 6'b001000) begin errors++; $display("FAIL br_mem got=%b exp=%b", ctl(), 6'b001000); end
        tick();
        EX_MEM_MemRead = 1'b0; EX_MEM_RegisterRd = 5'd0;
        #1;
        checks++; if (ctl() !== 6'b110001) begin errors++; $display("FAIL br_taken got=%b exp=%b", ctl(), 6'b110001); end
        tick();
        idle_inputs();
        #1;
        checks++; if (IF_ID_Flush !== 1'b0) begin errors++; $display("FAIL br_flush_end got=%b exp=0", IF_ID_Flush); end
        checks++; if (StallCycles !== 4'd4) begin errors++; $display("FAIL br_cnt got=%0d exp=4", StallCycles); end
    endtask

    task automatic test_multiply;
        EX_MulStart = 1'b1;
        #1;
        checks++; if (HazardState !== 2'b00 || PCWrite !== 1'b1) begin errors++; $display("FAIL mul_start got=%b/%b exp=00/1", HazardState, PCWrite); end
        tick();
        for (int i = 0; i < 3; i++) begin
            EX_MulStart = (i < 2);
            ID_EX_MemRead = (i < 2); ID_EX_RegisterRd = 5'd8; IF_ID_RegisterRs = 5'd8;
            #1;
            checks++; if (HazardState !== 2'b01) begin errors++; $display("FAIL mul_state[%0d] got=%b exp=01", i, HazardState); end
            checks++; if (ctl() !== 6'b000110) begin errors++; $display("FAIL mul_ctl[%0d] got=%b exp=%b", i, ctl(), 6'b000110); end
            tick();
        end
        idle_inputs();
        #1;
        checks++; if (HazardState !== 2'b00 || ctl() !== 6'b110000) begin errors++; $display("FAIL mul_done got=%b/%b exp=00/110000", HazardState, ctl()); end
        checks++; if (StallCycles !== 4'd7) begin errors++; $display("FAIL mul_cnt got=%0d exp=7", StallCycles); end
        tick();
    endtask

    task automatic test_reset_mid_busy;
        EX_MulStart = 1'b1;
        tick();
        EX_MulStart = 1'b0;
        #1;
        checks++; if (HazardState !== 2'b01) begin errors++; $display("FAIL rmb_busy got=%b exp=01", HazardState); end
        Rst = 1'b0;
        #1;
        checks++; if (ctl() !== 6'b001000) begin errors++; $display("FAIL rmb_ctl got=%b exp=%b", ctl(), 6'b001000); end
        checks++; if (HazardState !== 2'b00 || StallCycles !== 4'd0) begin errors++; $display("FAIL rmb_state got=%b/%0d exp=00/0", HazardState, StallCycles); end
        #1;
        Rst = 1'b1;
        tick();
        checks++; if (HazardState !== 2'b00 || PCWrite !== 1'b1) begin errors++; $display("FAIL rmb_after got=%b/%b exp=00/1", HazardState, PCWrite); end
    endtask

    task automatic test_saturation;
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRd = 5'd12; IF_ID_RegisterRs = 5'd12;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (StallCycles !== 4'd10) begin errors++; $display("FAIL sat_mid got=%0d exp=10", StallCycles); end
        for (int i = 0; i < 10; i++) tick();
        checks++; if (StallCycles !== 4'hF) begin errors++; $display("FAIL sat_full got=%0d exp=15", StallCycles); end
        idle_inputs();
        tick();
        checks++; if (StallCycles !== 4'hF) begin errors++; $display("FAIL sat_hold got=%0d exp=15", StallCycles); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rt_gating();
        test_branch();
        test_multiply();
        test_reset_mid_busy();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
